// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Holds the active-low segment patterns {g..a}, the blank pattern, and seg_t.
package ssd_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned BCD_W = 4;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;

endpackage

// File: rtl/ssd_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: i_bcd  - 4-bit BCD code
//        o_seg_c - segments {g..a}, active-low; codes 10..15 give SEG_BLANK
module ssd_decode
   import ssd_pkg::*;
(
   input  logic [BCD_W-1:0] i_bcd,
   output seg_t             o_seg_c
);

   always_comb begin
      o_seg_c = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg_c = SEG_0;
         4'd1:    o_seg_c = SEG_1;
         4'd2:    o_seg_c = SEG_2;
         4'd3:    o_seg_c = SEG_3;
         4'd4:    o_seg_c = SEG_4;
         4'd5:    o_seg_c = SEG_5;
         4'd6:    o_seg_c = SEG_6;
         4'd7:    o_seg_c = SEG_7;
         4'd8:    o_seg_c = SEG_8;
         4'd9:    o_seg_c = SEG_9;
         default: o_seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed multi-digit seven-segment scan driver.
// Latches a packed BCD word, scans one digit per CLK_DIV-clock slot with
// BLANK_CYCLES of anode dead time, optional leading-zero blanking, and
// optional per-digit blinking (built only when SSD_SCAN_BLINK_EN is defined).
// Ports: clk, rst_n (async active-low), load_i/data_i (shadow load),
//        lzb_i (leading-zero blanking), blink_mask_i (per-digit blink),
//        seg_o (active-low segments, registered), an_o (active-low anodes, registered)
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 2,
   parameter int unsigned BLINK_FRAMES = 64
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_i,
   input  logic [BCD_W*NUM_DIGITS-1:0] data_i,
   input  logic                        lzb_i,
   input  logic [NUM_DIGITS-1:0]       blink_mask_i,
   output seg_t                        seg_o,
   output logic [NUM_DIGITS-1:0]       an_o
);

   localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;
   localparam int unsigned CNT_W  = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [DATA_W-1:0] r_shadow;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic              w_slot_end;
   logic              w_frame_end;
   logic [BCD_W-1:0]  w_digit;
   logic              w_upper_zero;
   logic              w_mask_bit;
   logic              w_blink_off;
   seg_t              w_dec_seg;
   seg_t              w_seg_nxt;
   logic [NUM_DIGITS-1:0] w_an_nxt;

   assign w_slot_end  = (r_cnt == CNT_W'(CLK_DIV - 1));
   assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

   // Shadow data and scan position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
      end else begin
         if (load_i) r_shadow <= data_i;
         if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Select the current digit, its blink bit, and whether it and all higher digits are zero
   always_comb begin
      w_digit      = '0;
      w_mask_bit   = 1'b0;
      w_upper_zero = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_digit      = r_shadow[BCD_W*k +: BCD_W];
            w_mask_bit   = blink_mask_i[k];
            w_upper_zero = (k > 0) && ((r_shadow >> (BCD_W*k)) == '0);
         end
      end
   end

`ifdef SSD_SCAN_BLINK_EN
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FRM_W-1:0] r_frame;
   logic             r_phase_on;

   // Blink phase toggles every BLINK_FRAMES completed frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame    <= '0;
         r_phase_on <= 1'b1;
      end else if (w_frame_end) begin
         if (r_frame == FRM_W'(BLINK_FRAMES - 1)) begin
            r_frame    <= '0;
            r_phase_on <= ~r_phase_on;
         end else begin
            r_frame <= r_frame + FRM_W'(1);
         end
      end
   end

   assign w_blink_off = !r_phase_on && w_mask_bit;
`else
   assign w_blink_off = 1'b0;

   logic w_unused_blink;
   assign w_unused_blink = w_mask_bit;
`endif

   ssd_decode u_decode (
      .i_bcd   (w_digit),
      .o_seg_c (w_dec_seg)
   );

   // Next output value; blanking priority: dead time, blink-off, LZB, then decode
   always_comb begin
      w_seg_nxt = w_dec_seg;
      w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
      if (r_cnt < CNT_W'(BLANK_CYCLES)) begin
         w_seg_nxt = SEG_BLANK;
         w_an_nxt  = '1;
      end else if (w_blink_off) begin
         w_seg_nxt = SEG_BLANK;
      end else if (lzb_i && w_upper_zero) begin
         w_seg_nxt = SEG_BLANK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_o <= SEG_BLANK;
         an_o  <= '1;
      end else begin
         seg_o <= w_seg_nxt;
         an_o  <= w_an_nxt;
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (NUM_DIGITS=4, CLK_DIV=4,
// BLANK_CYCLES=1, BLINK_FRAMES=2). Expected outputs come from a time-based
// reference model indexed by cycles since reset release.
module tb_ssd_scan_driver;

   localparam int ND = 4;
   localparam int CD = 4;
   localparam int BC = 1;
   localparam int BF = 2;

   logic        clk;
   logic        rst_n;
   logic        load_i;
   logic [15:0] data_i;
   logic        lzb_i;
   logic [3:0]  blink_mask_i;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;

   ssd_scan_driver #(
      .NUM_DIGITS   (ND),
      .CLK_DIV      (CD),
      .BLANK_CYCLES (BC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load_i),
      .data_i       (data_i),
      .lzb_i        (lzb_i),
      .blink_mask_i (blink_mask_i),
      .seg_o        (seg_o),
      .an_o         (an_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [6:0]  tab [16];
   int          t;      // cycles since reset release
   logic [15:0] sh;     // model shadow value
   logic [6:0]  s_seg;
   logic [3:0]  s_an;

   typedef struct {
      logic [15:0] data;
      logic        lzb;
      int          digit;
      logic [6:0]  exp_seg;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
      end
   endtask

   // Expected {seg, an} for the output register after the edge ending cycle tt
   function automatic logic [10:0] model(input int tt, input logic [15:0] s,
                                         input logic lz, input logic [3:0] m);
      int cnt, idx, frm;
      logic [6:0] sg;
      logic [3:0] an;
      logic [3:0] dg;
      cnt = tt % CD;
      idx = (tt / CD) % ND;
      frm = tt / (CD * ND);
      if (cnt < BC) return {7'h7F, 4'hF};
      an = 4'hF;
      an[idx] = 1'b0;
      dg = 4'((s >> (4*idx)) & 16'hF);
      sg = tab[dg];
      if (lz && idx > 0 && (s >> (4*idx)) == 16'h0) sg = 7'h7F;
`ifdef SSD_SCAN_BLINK_EN
      if (((frm / BF) % 2) == 1 && m[idx]) sg = 7'h7F;
`else
      if (m == 4'hF && frm < 0) sg = 7'h7F;
`endif
      return {sg, an};
   endfunction

   task automatic step(input logic ld, input logic [15:0] d, input logic lz, input logic [3:0] m);
      logic [10:0] e;
      e = model(t, sh, lz, m);
      load_i = ld; data_i = d; lzb_i = lz; blink_mask_i = m;
      @(posedge clk);
      t++;
      if (ld) sh = d;
      @(negedge clk);
      s_seg = seg_o;
      s_an  = an_o;
      chk("seg", 32'(s_seg), 32'(e[10:4]));
      chk("an",  32'(s_an),  32'(e[3:0]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      load_i = 1'b0; data_i = '0; lzb_i = 1'b0; blink_mask_i = '0;
      @(negedge clk);
      chk("rst_seg", 32'(seg_o), 32'h7F);
      chk("rst_an",  32'(an_o),  32'hF);
      rst_n = 1'b1;
      t  = 0;
      sh = '0;
   endtask

   initial begin
      int hits, n_on, n_off;
      logic [15:0] rd;
      logic        lit;

      tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100; tab[3] = 7'b0110000;
      tab[4] = 7'b0011001; tab[5] = 7'b0010010; tab[6] = 7'b0000010; tab[7] = 7'b1111000;
      tab[8] = 7'b0000000; tab[9] = 7'b0010000;
      for (int i = 10; i < 16; i++) tab[i] = 7'h7F;

      vecs[0]  = '{16'h1234, 1'b0, 0, 7'b0011001};
      vecs[1]  = '{16'h1234, 1'b0, 1, 7'b0110000};
      vecs[2]  = '{16'h1234, 1'b0, 2, 7'b0100100};
      vecs[3]  = '{16'h1234, 1'b0, 3, 7'b1111001};
      vecs[4]  = '{16'h0050, 1'b1, 3, 7'b1111111};
      vecs[5]  = '{16'h0050, 1'b1, 2, 7'b1111111};
      vecs[6]  = '{16'h0050, 1'b1, 1, 7'b0010010};
      vecs[7]  = '{16'h0050, 1'b1, 0, 7'b1000000};
      vecs[8]  = '{16'h0000, 1'b1, 1, 7'b1111111};
      vecs[9]  = '{16'h0000, 1'b1, 0, 7'b1000000};
      vecs[10] = '{16'h00AF, 1'b0, 0, 7'b1111111};
      vecs[11] = '{16'h00AF, 1'b0, 1, 7'b1111111};

      t = 0; sh = '0;
      rst_n = 1'b0; load_i = 1'b0; data_i = '0; lzb_i = 1'b0; blink_mask_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_seg", 32'(seg_o), 32'h7F);
      chk("rst_an",  32'(an_o),  32'hF);
      rst_n = 1'b1;

      // Idle scan after reset: every digit shows 0
      for (int i = 0; i < 2*ND*CD; i++) step(1'b0, 16'h0, 1'b0, 4'h0);

      // Table vectors: load, then compare the target digit while its anode is low
      for (int v = 0; v < 12; v++) begin
         hits = 0;
         step(1'b1, vecs[v].data, vecs[v].lzb, 4'h0);
         for (int i = 0; i < 2*ND*CD; i++) begin
            step(1'b0, 16'h0, vecs[v].lzb, 4'h0);
            if (s_an == ~(4'b0001 << vecs[v].digit)) begin
               hits++;
               chk($sformatf("vec%0d_seg", v), 32'(s_seg), 32'(vecs[v].exp_seg));
            end
         end
         chk($sformatf("vec%0d_anode_hits", v), 32'(hits > 0), 32'd1);
      end

      // Back-to-back loads: last one wins
      step(1'b1, 16'h9999, 1'b0, 4'h0);
      step(1'b1, 16'h8765, 1'b0, 4'h0);
      for (int i = 0; i < ND*CD; i++) step(1'b0, 16'h0, 1'b0, 4'h0);

      // Blink sequence aligned to reset: digit 0 lit 3 samples per frame over 8 frames
      do_reset();
      n_on = 0; n_off = 0;
      for (int i = 0; i < 8*ND*CD; i++) begin
         step(i == 0, 16'h0007, 1'b0, 4'b0001);
         if (s_an == 4'b1110) begin
            if (s_seg == 7'b1111000) n_on++;
            else if (s_seg == 7'h7F) n_off++;
         end
      end
`ifdef SSD_SCAN_BLINK_EN
      chk("blink_on_count",  32'(n_on),  32'd12);
      chk("blink_off_count", 32'(n_off), 32'd12);
`else
      chk("blink_on_count",  32'(n_on),  32'd24);
      chk("blink_off_count", 32'(n_off), 32'd0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 4; k++)
            rd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         step($urandom_range(0, 7) == 0, rd, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      // Reset mid-slot on digit 2, then restart from digit 0
      for (int i = 0; i < ND*CD && (t % (ND*CD)) != 2*CD + 2; i++)
         step(1'b0, 16'h0, 1'b0, 4'h0);
      chk("pre_rst_an_digit2", 32'(an_o), 32'b1011);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_seg", 32'(seg_o), 32'h7F);
      chk("async_rst_an",  32'(an_o),  32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0; sh = '0;
      lit = 1'b0;
      for (int i = 0; i < 2*CD && !lit; i++) begin
         step(1'b0, 16'h0, 1'b0, 4'h0);
         if (s_an != 4'hF) begin
            lit = 1'b1;
            chk("first_lit_an", 32'(s_an), 32'b1110);
         end
      end
      chk("first_lit_seen", 32'(lit), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
